pm_loader: RTL

Program-memory loader for the uProcessor: accepts a framed byte stream and writes it into the program memory write port that sits beside the ProgramCounter/instruction-decoder read path. While a load is in progress the loader holds the CPU core (ProgramCounter plus RF/ALU/CY/A datapath) in reset through its own active-low reset output. The CPU is released only after a complete frame, with a valid checksum when that is enabled, has been written. The block is the writer at the other end of the program memory the decoder reads.

---
 rtl/pm_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pm_loader.sv
// pm_loader
//
// Program-memory loader for the uProcessor. It takes a framed byte stream
// and writes the words into the program memory write port. While a frame
// is in flight, the CPU core is held in reset. The CPU is released only
// once a complete frame has been written and, if enabled, its checksum
// has been verified.
//
// Frame: header byte N (word count, 1..2^ADDR_W), then N instruction bytes,
// then one checksum byte when PM_LOADER_CHECKSUM_EN is defined. The
// checksum makes (N + data bytes + checksum) mod 256 == 0.
//
// Build option:
//   PM_LOADER_CHECKSUM_EN - adds the CHK state and the running sum.
//
// Ports:
//   clk        in   rising-edge clock
//   nReset     in   synchronous active-low reset
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader can accept a byte (combinational, 0 in reset)
//   start      in   one-cycle pulse, restarts loading from DONE or ERR
//   pm_addr    out  program memory write address
//   pm_wdata   out  program memory write data
//   pm_we      out  program memory write enable, one pulse per word
//   cpu_nReset out  active-low reset to the CPU core
//   busy       out  frame in progress (DATA / CHK)
//   done       out  load completed successfully
//   error      out  frame rejected

module pm_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              pm_we,
    output logic              cpu_nReset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
`ifdef PM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHK  = 3'd2;
`endif
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic [2:0]      state;
    // One bit wider than the address so that a full-depth frame (N = DEPTH)
    // can be counted without wrapping.
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] index_inc;
    logic            header_bad;
    logic            accept;
`ifdef PM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_final;
`endif

    // The loader is ready in the frame-receiving states only. The reset
    // qualifier keeps upstream from handing over a byte that the reset
    // edge would throw away.
    always_comb begin
        in_ready = 1'b0;
        if (nReset) begin
            case (state)
                ST_IDLE: in_ready = 1'b1;
                ST_DATA: in_ready = 1'b1;
`ifdef PM_LOADER_CHECKSUM_EN
                ST_CHK:  in_ready = 1'b1;
`endif
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept     = in_valid && in_ready;
    assign index_inc  = index + {{ADDR_W{1'b0}}, 1'b1};
    // A header of zero words, or more words than the memory holds, cannot
    // be loaded.
    assign header_bad = (in_data == '0) || (int'(in_data) > DEPTH);
`ifdef PM_LOADER_CHECKSUM_EN
    assign sum_final  = sum + in_data;
`endif

    // Frame state machine and registered outputs. pm_we defaults low, so
    // each accepted data byte produces exactly one write pulse on the
    // following cycle. On the final byte, the last write and the CPU release
    // land in the same cycle. The PC only fetches one edge after that, so
    // the last word is already in memory by then.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state      <= ST_IDLE;
            count      <= '0;
            index      <= '0;
            pm_addr    <= '0;
            pm_wdata   <= '0;
            pm_we      <= 1'b0;
            cpu_nReset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef PM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            pm_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (header_bad) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            count <= in_data[ADDR_W:0];
                            index <= '0;
`ifdef PM_LOADER_CHECKSUM_EN
                            sum   <= in_data;
`endif
                            state <= ST_DATA;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
                        pm_addr  <= index[ADDR_W-1:0];
                        pm_wdata <= in_data;
                        pm_we    <= 1'b1;
                        index    <= index_inc;
`ifdef PM_LOADER_CHECKSUM_EN
                        sum      <= sum + in_data;
                        if (index_inc == count) begin
                            state <= ST_CHK;
                        end
`else
                        if (index_inc == count) begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            cpu_nReset <= 1'b1;
                        end
`endif
                    end
                end

`ifdef PM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (sum_final == '0) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            cpu_nReset <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state      <= ST_IDLE;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_nReset <= 1'b0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    error      <= 1'b0;
                    cpu_nReset <= 1'b0;
                end
            endcase
        end
    end

endmodule
